// File: rtl/cic_decim.sv
// I/Q CIC decimator: STAGES integrators at input rate, decimate by RATE, STAGES combs at output rate.
// Build option CIC_DECIM_ROUND_EN: round half up with positive saturation in the output stage.
module cic_decim #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int STAGES    = 3,
  parameter int RATE      = 8,
  parameter int DELAY     = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [IN_WIDTH-1:0]  i_inph_data,
  input  logic [IN_WIDTH-1:0]  i_quad_data,
  input  logic                 i_valid,
  output logic [OUT_WIDTH-1:0] o_inph_data,
  output logic [OUT_WIDTH-1:0] o_quad_data,
  output logic                 o_valid
);

  localparam int ACC_WIDTH = IN_WIDTH + STAGES * $clog2(RATE * DELAY);
  localparam int SHIFT     = ACC_WIDTH - OUT_WIDTH;
  localparam int CNT_W     = $clog2(RATE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);

  // Index 0 is the in-phase path, index 1 the quadrature path.
  logic signed [ACC_WIDTH-1:0] w_in     [2];
  logic signed [ACC_WIDTH-1:0] r_integ  [2][STAGES];
  logic signed [ACC_WIDTH-1:0] r_dec    [2];
  logic                        r_dec_vld;
  logic        [CNT_W-1:0]     r_count;

  logic signed [ACC_WIDTH-1:0] w_cin    [2][STAGES];
  logic        [STAGES-1:0]    w_cvin;
  logic signed [ACC_WIDTH-1:0] r_comb   [2][STAGES];
  logic signed [ACC_WIDTH-1:0] r_z      [2][STAGES][DELAY];
  logic        [STAGES-1:0]    r_cvld;

  logic        [OUT_WIDTH-1:0] w_out    [2];

  assign w_in[0] = ACC_WIDTH'($signed(i_inph_data));
  assign w_in[1] = ACC_WIDTH'($signed(i_quad_data));

  // Integrators wrap modulo 2^ACC_WIDTH by design; the combs undo the wrap.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < STAGES; k++) r_integ[p][k] <= '0;
        r_dec[p] <= '0;
      end
      r_count   <= '0;
      r_dec_vld <= 1'b0;
    end else begin
      r_dec_vld <= 1'b0;
      if (i_valid) begin
        for (int p = 0; p < 2; p++) begin
          r_integ[p][0] <= r_integ[p][0] + w_in[p];
          for (int k = 1; k < STAGES; k++) r_integ[p][k] <= r_integ[p][k] + r_integ[p][k-1];
        end
        if (r_count == CNT_LAST) begin
          r_count   <= '0;
          r_dec_vld <= 1'b1;
          for (int p = 0; p < 2; p++) r_dec[p] <= r_integ[p][STAGES-1];
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_cin[p][0] = r_dec[p];
      for (int k = 1; k < STAGES; k++) w_cin[p][k] = r_comb[p][k-1];
    end
    w_cvin[0] = r_dec_vld;
    for (int k = 1; k < STAGES; k++) w_cvin[k] = r_cvld[k-1];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cvld <= '0;
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < STAGES; k++) begin
          r_comb[p][k] <= '0;
          for (int d = 0; d < DELAY; d++) r_z[p][k][d] <= '0;
        end
      end
    end else begin
      r_cvld <= w_cvin;
      for (int k = 0; k < STAGES; k++) begin
        if (w_cvin[k]) begin
          for (int p = 0; p < 2; p++) begin
            r_comb[p][k] <= w_cin[p][k] - r_z[p][k][DELAY-1];
            r_z[p][k][0] <= w_cin[p][k];
            for (int d = 1; d < DELAY; d++) r_z[p][k][d] <= r_z[p][k][d-1];
          end
        end
      end
    end
  end

`ifdef CIC_DECIM_ROUND_EN
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_WIDTH:0] ROUND_ONE = (SHIFT > 0) ? ((ACC_WIDTH + 1)'(1) << RND_SH) : '0;

  logic signed [ACC_WIDTH:0] w_sum [2];
  logic signed [ACC_WIDTH:0] w_rs  [2];
  logic                      w_ovf [2];

  // Rounding can only overflow upward, so only the positive rail needs clamping.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_sum[p] = {r_comb[p][STAGES-1][ACC_WIDTH-1], r_comb[p][STAGES-1]} + ROUND_ONE;
      w_rs[p]  = w_sum[p] >>> SHIFT;
      w_ovf[p] = !w_rs[p][ACC_WIDTH] && (|w_rs[p][ACC_WIDTH-1:OUT_WIDTH-1]);
      w_out[p] = w_ovf[p] ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : w_rs[p][OUT_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    for (int p = 0; p < 2; p++) w_out[p] = OUT_WIDTH'(r_comb[p][STAGES-1] >>> SHIFT);
  end
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_inph_data <= '0;
      o_quad_data <= '0;
      o_valid     <= 1'b0;
    end else begin
      o_valid <= r_cvld[STAGES-1];
      if (r_cvld[STAGES-1]) begin
        o_inph_data <= w_out[0];
        o_quad_data <= w_out[1];
      end
    end
  end

endmodule

// File: tb/tb_cic_decim.sv
// Bench for cic_decim: a 16-bit and a 12-bit output instance share stimulus; outputs are
// predicted by an FIR model (boxcar^N impulse response sampled every RATE inputs).
module tb_cic_decim;

  localparam int IW  = 16;
  localparam int ST  = 3;
  localparam int RT  = 8;
  localparam int DL  = 1;
  localparam int ACC = IW + ST * $clog2(RT * DL);
  localparam int SH16 = ACC - 16;
  localparam int SH12 = ACC - 12;
  localparam int LAT = ST + 2;

  logic          clk;
  logic          rst;
  logic [IW-1:0] din_i;
  logic [IW-1:0] din_q;
  logic          din_v;
  logic [15:0]   o_i16, o_q16;
  logic          o_v16;
  logic [11:0]   o_i12, o_q12;
  logic          o_v12;

  cic_decim #(.IN_WIDTH(IW), .OUT_WIDTH(16), .STAGES(ST), .RATE(RT), .DELAY(DL)) dut16 (
    .i_clock(clk), .i_reset(rst), .i_inph_data(din_i), .i_quad_data(din_q), .i_valid(din_v),
    .o_inph_data(o_i16), .o_quad_data(o_q16), .o_valid(o_v16));

  cic_decim #(.IN_WIDTH(IW), .OUT_WIDTH(12), .STAGES(ST), .RATE(RT), .DELAY(DL)) dut12 (
    .i_clock(clk), .i_reset(rst), .i_inph_data(din_i), .i_quad_data(din_q), .i_valid(din_v),
    .o_inph_data(o_i12), .o_quad_data(o_q12), .o_valid(o_v12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint g [0:255];
  int     glen;
  longint hist_i [$];
  longint hist_q [$];

  typedef struct {
    int     cyc;
    longint yi;
    longint yq;
  } pend_t;
  pend_t pend [$];

  initial begin
    longint t [0:255];
    for (int i = 0; i < 256; i++) g[i] = 0;
    g[0] = 1;
    glen = 1;
    for (int s = 0; s < ST; s++) begin
      for (int i = 0; i < 256; i++) t[i] = 0;
      for (int i = 0; i < glen; i++)
        for (int k = 0; k < RT * DL; k++) t[i+k] += g[i];
      glen += RT * DL - 1;
      g = t;
    end
  end

  // Decimated sample m is the filtered stream at input index m*RATE+RATE-1, delayed by STAGES samples.
  function automatic longint model_y(int m, bit use_q);
    longint acc = 0;
    longint modv = longint'(1) << ACC;
    int n = m * RT + RT - 1 - ST;
    for (int j = 0; j <= n; j++)
      if (n - j < glen) acc += g[n-j] * (use_q ? hist_q[j] : hist_i[j]);
    acc = acc % modv;
    if (acc < 0) acc += modv;
    if (acc >= modv / 2) acc -= modv;
    return acc;
  endfunction

  function automatic longint quant(longint y, int sh, int ow);
    longint r;
`ifdef CIC_DECIM_ROUND_EN
    longint one = 1;
    if (sh > 0) begin
      r = (y + (one << (sh - 1))) >>> sh;
      if (r > (one << (ow - 1)) - 1) r = (one << (ow - 1)) - 1;
    end else begin
      r = y;
    end
`else
    r = y >>> sh;
`endif
    return r;
  endfunction

  // ---------------- compare process ----------------
  int     cyc = 0;
  bit     armed = 0;
  longint h_i16 = 0, h_q16 = 0, h_i12 = 0, h_q12 = 0;
  int     n_strobe = 0;
  int     first_cyc = -1;
  int     last_cyc = -1;
  int     period = -1;
  longint last_i16 = 0, last_q16 = 0, last_i12 = 0, last_q12 = 0;
  pend_t  e;
  bit     ev;

  always @(negedge clk) begin
    if (armed) begin
      while (pend.size() > 0 && pend[0].cyc < cyc) void'(pend.pop_front());
      ev = (pend.size() > 0 && pend[0].cyc == cyc);
      chk("o_valid16", 64'(o_v16), 64'(ev));
      chk("o_valid12", 64'(o_v12), 64'(ev));
      if (ev) begin
        e = pend.pop_front();
        h_i16 = quant(e.yi, SH16, 16);
        h_q16 = quant(e.yq, SH16, 16);
        h_i12 = quant(e.yi, SH12, 12);
        h_q12 = quant(e.yq, SH12, 12);
      end
      chk("inph16", $signed(o_i16), h_i16);
      chk("quad16", $signed(o_q16), h_q16);
      chk("inph12", $signed(o_i12), h_i12);
      chk("quad12", $signed(o_q12), h_q12);
      if (o_v16 === 1'b1) begin
        if (n_strobe == 0) first_cyc = cyc;
        else period = cyc - last_cyc;
        last_cyc = cyc;
        n_strobe++;
        last_i16 = $signed(o_i16);
        last_q16 = $signed(o_q16);
        last_i12 = $signed(o_i12);
        last_q12 = $signed(o_q12);
      end
    end
    if (rst) begin
      armed = 1;
      hist_i.delete();
      hist_q.delete();
      pend.delete();
      h_i16 = 0; h_q16 = 0; h_i12 = 0; h_q12 = 0;
      n_strobe = 0; first_cyc = -1; last_cyc = -1; period = -1;
    end else if (armed && din_v) begin
      hist_i.push_back(longint'($signed(din_i)));
      hist_q.push_back(longint'($signed(din_q)));
      if (hist_i.size() % RT == 0) begin
        e.cyc = cyc + LAT;
        e.yi  = model_y(hist_i.size() / RT - 1, 1'b0);
        e.yq  = model_y(hist_i.size() / RT - 1, 1'b1);
        pend.push_back(e);
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step(bit r, bit v, int di, int dq);
    rst   = r;
    din_v = v;
    din_i = IW'(di);
    din_q = IW'(dq);
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n, bit toggle, int di, int dq);
    for (int k = 0; k < n; k++) step(1'b0, toggle ? (k % 2 == 0) : 1'b1, di, dq);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 0, 0);
  endtask

  int f;
  bit rnd;

  initial begin
`ifdef CIC_DECIM_ROUND_EN
    rnd = 1'b1;
`else
    rnd = 1'b0;
`endif
    rst = 1'b1; din_v = 1'b0; din_i = '0; din_q = '0;

    // Reset dominates a busy full-scale input.
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 32767, 32767);
    chk("rst_valid", 64'(o_v16), 0);
    chk("rst_inph", $signed(o_i16), 0);
    chk("rst_quad12", $signed(o_q12), 0);

    // DC, continuous valids.
    run(64, 1'b0, 1000, -1000);
    chk("dc_count", n_strobe, 8);
    chk("dc_period", period, 8);
    chk("dc_i16", last_i16, 1000);
    chk("dc_q16", last_q16, -1000);
    chk("dc_i12", last_i12, rnd ? 63 : 62);
    chk("dc_q12", last_q12, rnd ? -62 : -63);

    // DC, valid every other cycle.
    step(1'b1, 1'b0, 0, 0); step(1'b1, 1'b0, 0, 0);
    run(128, 1'b1, 1000, -1000);
    chk("gap_count", n_strobe, 8);
    chk("gap_period", period, 16);
    chk("gap_i16", last_i16, 1000);
    chk("gap_q16", last_q16, -1000);

    // Full scale: integrators wrap, outputs do not.
    step(1'b1, 1'b0, 0, 0); step(1'b1, 1'b0, 0, 0);
    run(48, 1'b0, 32767, -32768);
    chk("fs_i16", last_i16, 32767);
    chk("fs_q16", last_q16, -32768);
    chk("fs_i12", last_i12, 2047);
    chk("fs_q12", last_q12, -2048);

    // Small DC exposes truncation versus rounding on the 12-bit instance.
    step(1'b1, 1'b0, 0, 0); step(1'b1, 1'b0, 0, 0);
    run(48, 1'b0, 8, -8);
    chk("small_i16", last_i16, 8);
    chk("small_q16", last_q16, -8);
    chk("small_i12", last_i12, rnd ? 1 : 0);
    chk("small_q12", last_q12, rnd ? 0 : -1);

    // Reset in the middle of a group discards the partial group.
    step(1'b1, 1'b0, 0, 0); step(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1000, -1000);
    step(1'b1, 1'b0, 0, 0);
    f = cyc;
    run(40, 1'b0, 1000, -1000);
    chk("midrst_first", first_cyc, f + RT - 1 + LAT);
    chk("midrst_count", n_strobe, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
